sprite_line_scanner: RTL

SPRITE_LINE_SCANNER -- requirements
Module: sprite_line_scanner

---
 rtl/sprite_pkg.sv | 32 +++
 rtl/sprite_cand_fifo.sv | 66 ++++++
 rtl/sprite_line_scanner.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/sprite_pkg.sv
// Shared types for the sprite line scanner: descriptor field positions,
// the candidate record handed to the drawer, and the scanner state encoding.
package sprite_pkg;

    // Descriptor word layout (32-bit, one per sprite)
    localparam int unsigned DESC_EN_BIT    = 31;
    localparam int unsigned DESC_HFLIP_BIT = 30;
    localparam int unsigned DESC_VFLIP_BIT = 29;
    localparam int unsigned DESC_Y_MSB     = 26;
    localparam int unsigned DESC_Y_LSB     = 18;
    localparam int unsigned DESC_X_MSB     = 17;
    localparam int unsigned DESC_X_LSB     = 8;
    localparam int unsigned DESC_FRAME_MSB = 7;
    localparam int unsigned DESC_FRAME_LSB = 0;

    // Row offset storage sized for the tallest supported sprite (64 rows)
    localparam int unsigned ROW_OFF_W_MAX  = 6;

    typedef struct packed {
        logic [9:0]               col_base;
        logic                     flip;
        logic [7:0]               frame_id;
        logic [ROW_OFF_W_MAX-1:0] row_off;
    } cand_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/sprite_cand_fifo.sv
// Candidate FIFO between the descriptor scanner and the line drawer.
// Registered storage with the head entry visible combinationally; push and
// pop may coincide even when full. Flush empties it in one cycle.
module sprite_cand_fifo
    import sprite_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  cand_t                    din,
    output cand_t                    dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    cand_t          mem_q [DEPTH];
    logic [PW-1:0]  wr_q;
    logic [PW-1:0]  rd_q;
    logic [CW-1:0]  cnt_q;
    logic           do_push;
    logic           do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CW'(DEPTH));
    assign count   = cnt_q;
    assign dout    = mem_q[rd_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Entry storage, written at the tail
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem_q[wr_q] <= din;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (flush) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/sprite_line_scanner.sv
// Sprite line scanner: walks the descriptor RAM for the line being prepared,
// queues sprites that intersect it and hands them to the drawer in index order.
// Optional feature macro: SPRITE_VFLIP_EN (honour descriptor bit 29 as a
// vertical flip of the row offset). Default build ignores bit 29.
module sprite_line_scanner
    import sprite_pkg::*;
#(
    parameter int unsigned NUM_SPRITE   = 32,
    parameter int unsigned MAX_SLOT     = 8,
    parameter int unsigned SPR_H        = 16,
    parameter int unsigned MAX_PER_LINE = 16,
    parameter int unsigned VIS_LINES    = 480
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start_row,
    input  logic [9:0]                    next_vcount,
    output logic [$clog2(NUM_SPRITE)-1:0] ra,
    input  logic [31:0]                   rd_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [9:0]                    col_base,
    output logic                          flip,
    output logic [7:0]                    frame_id,
    output logic [$clog2(SPR_H)-1:0]      row_off,
    output logic                          fe_done,
    output logic                          line_ovf
);

    localparam int unsigned AW  = $clog2(NUM_SPRITE);
    localparam int unsigned RW  = $clog2(SPR_H);
    localparam int unsigned CW  = $clog2(MAX_SLOT) + 1;
    localparam int unsigned ACW = $clog2(NUM_SPRITE + 1);
    localparam logic [AW-1:0] LAST_IDX = AW'(NUM_SPRITE - 1);

    state_t         state_q, state_d;
    logic [AW-1:0]  ra_q, ra_d;
    logic           issued_all_q, issued_all_d;
    logic           pend_q, pend_d;
    logic [AW-1:0]  pend_idx_q, pend_idx_d;
    logic [ACW-1:0] acc_q, acc_d;
    logic           ovf_q, ovf_d;

    logic           fifo_flush;
    logic           fifo_push;
    logic           fifo_full;
    logic           fifo_empty;
    logic [CW-1:0]  fifo_count;
    cand_t          push_cand;
    cand_t          head;

    logic [10:0]    vc11;
    logic [10:0]    y11;
    logic           hit;
    logic [RW-1:0]  row_raw;
    logic [RW-1:0]  row_sel;

    // Descriptor decode at 11 bits so y+SPR_H never wraps
    assign vc11    = {1'b0, next_vcount};
    assign y11     = {2'b00, rd_data[DESC_Y_MSB:DESC_Y_LSB]};
    assign hit     = rd_data[DESC_EN_BIT] && (vc11 >= y11) && (vc11 < y11 + 11'(SPR_H));
    assign row_raw = RW'(vc11 - y11);

`ifdef SPRITE_VFLIP_EN
    logic unused_desc_bits;
    assign unused_desc_bits = ^rd_data[28:27];
    // SPR_H is a power of two, so SPR_H-1-r equals the bitwise complement
    assign row_sel = rd_data[DESC_VFLIP_BIT] ? ~row_raw : row_raw;
`else
    logic unused_desc_bits;
    assign unused_desc_bits = ^rd_data[29:27];
    assign row_sel = row_raw;
`endif

    assign push_cand.col_base = rd_data[DESC_X_MSB:DESC_X_LSB];
    assign push_cand.flip     = rd_data[DESC_HFLIP_BIT];
    assign push_cand.frame_id = rd_data[DESC_FRAME_MSB:DESC_FRAME_LSB];
    assign push_cand.row_off  = ROW_OFF_W_MAX'(row_sel);

    sprite_cand_fifo #(
        .DEPTH (MAX_SLOT)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (fifo_flush),
        .push  (fifo_push),
        .pop   (out_ready),
        .din   (push_cand),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Scanner state, read pointer, in-flight tag and per-line accounting
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            ra_q         <= '0;
            issued_all_q <= 1'b0;
            pend_q       <= 1'b0;
            pend_idx_q   <= '0;
            acc_q        <= '0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            ra_q         <= ra_d;
            issued_all_q <= issued_all_d;
            pend_q       <= pend_d;
            pend_idx_q   <= pend_idx_d;
            acc_q        <= acc_d;
            ovf_q        <= ovf_d;
        end
    end

    // Next-state, issue and evaluate logic
    always_comb begin
        state_d      = state_q;
        ra_d         = ra_q;
        issued_all_d = issued_all_q;
        pend_d       = 1'b0;
        pend_idx_d   = pend_idx_q;
        acc_d        = acc_q;
        ovf_d        = ovf_q;
        fifo_flush   = 1'b0;
        fifo_push    = 1'b0;

        if (start_row) begin
            fifo_flush   = 1'b1;
            acc_d        = '0;
            ovf_d        = 1'b0;
            ra_d         = '0;
            issued_all_d = 1'b0;
            state_d      = (32'(next_vcount) < VIS_LINES) ? SCAN : IDLE;
        end else begin
            case (state_q)
                SCAN: begin
                    if (pend_q) begin
                        if (hit) begin
                            if (acc_q < ACW'(MAX_PER_LINE)) begin
                                fifo_push = 1'b1;
                                acc_d     = acc_q + 1'b1;
                            end else begin
                                ovf_d = 1'b1;
                            end
                        end
                        if (pend_idx_q == LAST_IDX) begin
                            state_d = DRAIN;
                        end
                    end
                    // Two free slots cover the read in flight plus this one
                    if (!issued_all_q && !fifo_full &&
                        (fifo_count <= CW'(MAX_SLOT - 2))) begin
                        pend_d     = 1'b1;
                        pend_idx_d = ra_q;
                        if (ra_q == LAST_IDX) begin
                            issued_all_d = 1'b1;
                        end else begin
                            ra_d = ra_q + 1'b1;
                        end
                    end
                end
                // The drawer's current candidate is the FIFO head, so an
                // empty FIFO means nothing is left to hand over
                DRAIN: begin
                    if (fifo_empty) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign ra        = ra_q;
    assign fe_done   = (state_q == IDLE);
    assign line_ovf  = ovf_q;
    assign out_valid = !fifo_empty;
    assign col_base  = out_valid ? head.col_base : '0;
    assign flip      = out_valid ? head.flip     : 1'b0;
    assign frame_id  = out_valid ? head.frame_id : '0;
    assign row_off   = out_valid ? RW'(head.row_off) : '0;

endmodule
